// File: rtl/ordered_exchange_pkg.sv
// Shared constants for the ordered two-party exchange: state encoding and
// default widths.
package ordered_exchange_pkg;

  localparam int DEFAULT_W  = 1;
  localparam int DEFAULT_CW = 8;

  localparam logic [1:0] IDLE    = 2'b00;
  localparam logic [1:0] HAVE_A  = 2'b01;
  localparam logic [1:0] HAVE_B  = 2'b10;
  localparam logic [1:0] DELIVER = 2'b11;

endpackage

// File: rtl/xchg_slot.sv
// Single-word holding register with a full flag; load wins over clear,
// reset wins over both.
module xchg_slot #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         clear,
  input  logic [W-1:0] d,
  output logic [W-1:0] q,
  output logic         full
);

  logic [W-1:0] data_r;
  logic         full_r;

  // Word storage and occupancy; the word itself is kept after clear so the
  // last delivered pair stays visible until overwritten.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_r <= {W{1'b0}};
      full_r <= 1'b0;
    end else if (load) begin
      data_r <= d;
      full_r <= 1'b1;
    end else if (clear) begin
      data_r <= data_r;
      full_r <= 1'b0;
    end else begin
      data_r <= data_r;
      full_r <= full_r;
    end
  end

  assign q    = data_r;
  assign full = full_r;

endmodule

// File: rtl/ordered_exchange.sv
// Clocked two-party exchange: collects one word from A and one from B, then
// presents them crossed (c = B word, d = A word) until the consumer accepts.
module ordered_exchange
  import ordered_exchange_pkg::*;
#(
  parameter int W  = DEFAULT_W,
  parameter int CW = DEFAULT_CW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          a_valid,
  input  logic [W-1:0]  a_data,
  output logic          a_ready,
  input  logic          b_valid,
  input  logic [W-1:0]  b_data,
  output logic          b_ready,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  c_data,
  output logic [W-1:0]  d_data,
  output logic [CW-1:0] xchg_count
);

  logic [1:0]    state_r;
  logic [1:0]    next_state_s;
  logic          a_accept_s;
  logic          b_accept_s;
  logic          deliver_s;
  logic          a_full_s;
  logic          b_full_s;
  logic [CW-1:0] count_r;

  // Ready is a pure decode of the state register, never of the valids.
  assign a_ready    = (state_r == IDLE) || (state_r == HAVE_B);
  assign b_ready    = (state_r == IDLE) || (state_r == HAVE_A);
  assign a_accept_s = a_valid && a_ready;
  assign b_accept_s = b_valid && b_ready;
  // Both slot flags gate the presentation so a partial pair can never appear.
  assign out_valid  = (state_r == DELIVER) && a_full_s && b_full_s;
  assign deliver_s  = out_valid && out_ready;

  // Next-state selection for the collect/deliver sequence.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (a_accept_s && b_accept_s) next_state_s = DELIVER;
        else if (a_accept_s)          next_state_s = HAVE_A;
        else if (b_accept_s)          next_state_s = HAVE_B;
        else                          next_state_s = IDLE;
      end
      HAVE_A: begin
        if (b_accept_s) next_state_s = DELIVER;
        else            next_state_s = HAVE_A;
      end
      HAVE_B: begin
        if (a_accept_s) next_state_s = DELIVER;
        else            next_state_s = HAVE_B;
      end
      DELIVER: begin
        if (deliver_s) next_state_s = IDLE;
        else           next_state_s = DELIVER;
      end
      default: next_state_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_r <= IDLE;
    else     state_r <= next_state_s;
  end

  // Completed-exchange counter, wrapping naturally at its width.
  always_ff @(posedge clk) begin
    if (rst)            count_r <= {CW{1'b0}};
    else if (deliver_s) count_r <= count_r + CW'(1);
    else                count_r <= count_r;
  end

  xchg_slot #(.W(W)) u_slot_a (
    .clk   (clk),
    .rst   (rst),
    .load  (a_accept_s),
    .clear (deliver_s),
    .d     (a_data),
    .q     (d_data),
    .full  (a_full_s)
  );

  xchg_slot #(.W(W)) u_slot_b (
    .clk   (clk),
    .rst   (rst),
    .load  (b_accept_s),
    .clear (deliver_s),
    .d     (b_data),
    .q     (c_data),
    .full  (b_full_s)
  );

  assign xchg_count = count_r;

endmodule

// File: doc/ordered_exchange.md
# ordered_exchange

Deterministic two-party value exchange for the assignment-series designs. Two independent producers, side A and side B, each hand over one word. Once both words are held, the block presents them crossed: output `c_data` carries B's word and `d_data` carries A's word. All ordering is fixed by clock edges, so the result is independent of which side arrives first. This is the clocked, race-free counterpart of the zero-delay cross-assignment exercises, and sits between two writer agents and a single consumer.

## Interface
- `W`, default 1: data width of each exchanged word.
- `CW`, default 8: width of the completed-exchange counter.

- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst`, input, 1: reset, synchronous, active-high.
- `a_valid`, input, 1: side A offers `a_data`.
- `a_data`, input, W: side A word.
- `a_ready`, output, 1: slot A is empty and can accept.
- `b_valid`, input, 1: side B offers `b_data`.
- `b_data`, input, W: side B word.
- `b_ready`, output, 1: slot B is empty and can accept.
- `out_valid`, output, 1: a crossed pair is being presented.
- `out_ready`, input, 1: consumer accepts the pair.
- `c_data`, output, W: the held B word (c = b).
- `d_data`, output, W: the held A word (d = a).
- `xchg_count`, output, CW: number of completed exchanges, wraps modulo 2^CW.

## Operation
- FSM states: `IDLE` (both slots empty), `HAVE_A`, `HAVE_B`, `DELIVER`.
- Ready outputs:
  - `a_ready` = state is `IDLE` or `HAVE_B`.
  - `b_ready` = state is `IDLE` or `HAVE_A`.
  - Both ready outputs are decoded from registered state only, with no combinational path from any valid input.
- Acceptance on side A: `a_valid & a_ready` at an edge captures `a_data` into slot A. Side B behaves the same way.
- Transitions:
  - `IDLE` with A only → `HAVE_A`.
  - `IDLE` with B only → `HAVE_B`.
  - `IDLE` with both in the same cycle → `DELIVER`.
  - `HAVE_A` with B → `DELIVER`.
  - `HAVE_B` with A → `DELIVER`.
  - `DELIVER` with `out_ready` → `IDLE`.
  - Every other case holds the current state.
- `out_valid` = (state == `DELIVER`). `c_data` and `d_data` are the slot registers and stay stable for the whole time `out_valid` is high.
- On handshake completion (`out_valid & out_ready`), `xchg_count` increments by 1. From 2^CW−1 it wraps to 0.
- A producer that holds `valid` while its slot is full is stalled and its data is not sampled. A second word from the same side is never accepted before delivery.
- Reset values: state `IDLE`, `a_ready` = 1, `b_ready` = 1, `out_valid` = 0, `c_data` = 0, `d_data` = 0, `xchg_count` = 0.
- Reset asserted mid-operation discards any held words at that edge. No partial pair is ever delivered.

## Timing
- Latency: the edge that captures the second word is N. `out_valid` is high during cycle N+1.
- Ready recovery: the delivery handshake at edge M makes both `a_ready` and `b_ready` high in cycle M+1.
- There is no bypass, so the peak rate is one exchange per 2 cycles.
- `out_valid` is never withdrawn until `out_ready` is seen.
- Simultaneous events:
  - A and B arriving on the same edge is a single transition to `DELIVER`.
  - During `DELIVER`, new valids are ignored because both ready outputs are low.
- `rst` takes priority over every handshake on the same edge.

## Structure
- A shared package holds:
  - the state encoding (`IDLE` = 2'b00, `HAVE_A` = 2'b01, `HAVE_B` = 2'b10, `DELIVER` = 2'b11);
  - the default `W` and `CW` constants.
- One sub-module, `xchg_slot`: a W-bit holding register with `load`, `clear` and `full` signals.
  - Instantiated twice, once for A and once for B.
  - The FSM, ready/valid decode and counter live in `ordered_exchange`.

## Test plan
- Reset check: hold `rst` = 1 for 2 cycles → `a_ready` = 1, `b_ready` = 1, `out_valid` = 0, `c_data` = 0, `d_data` = 0, `xchg_count` = 0.
- A first: A sends 0 at cycle 1, B sends 1 at cycle 3, with `out_ready` = 1 → `out_valid` high in cycle 4 with `c_data` = 1 and `d_data` = 0; `xchg_count` = 1 after that edge.
- Simultaneous arrival: A = 0 and B = 1 on the same edge → `DELIVER` in the next cycle with `c_data` = 1, `d_data` = 0; the ordering matches the A-first case.
- Backpressure: hold `out_ready` = 0 for 5 cycles with A and B valids asserted → data stable, `a_ready` = 0, `b_ready` = 0; releasing gives exactly one increment, then both ready outputs are high in the next cycle.
- Wrap and reset: with `CW` = 2, run 5 exchanges → `xchg_count` sequence 1, 2, 3, 0, 1. Asserting `rst` while in `HAVE_A` → `IDLE`, and no `out_valid` follows.
